// File: rtl/hps_pio_pkg.sv
// Shared encodings for the HPS PIO master: command ops, response status and FSM states.
package hps_pio_pkg;

    typedef enum logic [1:0] {
        OP_WRITE = 2'd0,
        OP_READ  = 2'd1,
        OP_POLL  = 2'd2,
        OP_RSVD  = 2'd3
    } op_e;

    typedef enum logic [1:0] {
        ST_OK             = 2'd0,
        ST_WAIT_TIMEOUT   = 2'd1,
        ST_POLL_EXHAUSTED = 2'd2,
        ST_BAD_OP         = 2'd3
    } status_e;

    // state | meaning
    // IDLE  | waiting for a command, cmd_ready high
    // ISSUE | chipselect asserted, waiting out waitrequest
    // LAT   | read accepted, counting down to readdata valid
    // EVAL  | captured read data inspected (READ done / POLL compare)
    // RESP  | response held until rsp_ready
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ISSUE = 3'd1,
        S_LAT   = 3'd2,
        S_EVAL  = 3'd3,
        S_RESP  = 3'd4
    } state_e;

    // Wide enough for READ_LATENCY-1 with READ_LATENCY up to 4.
    localparam int LAT_CNT_W = 3;

endpackage

// File: rtl/hps_pio_lat_pipe.sv
// Read-latency timer: loaded when a read leaves ISSUE, strobes capture on the
// cycle in which avm_readdata is valid (READ_LATENCY cycles after the accepted read).
module hps_pio_lat_pipe
    import hps_pio_pkg::*;
#(
    parameter int READ_LATENCY = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    output logic capture
);

    logic [LAT_CNT_W-1:0] cnt;
    logic                 busy;

    // Down-counter: terminal count of zero while busy marks the data-valid cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt  <= '0;
            busy <= 1'b0;
        end else if (start) begin
            cnt  <= LAT_CNT_W'(READ_LATENCY - 1);
            busy <= 1'b1;
        end else if (busy) begin
            if (cnt == '0)
                busy <= 1'b0;
            else
                cnt <= cnt - 1'b1;
        end
    end

    assign capture = busy && (cnt == '0);

endmodule

// File: rtl/hps_pio_master.sv
// Command-driven Avalon-MM master for PIO-style slaves: single WRITE, single READ,
// or POLL (repeated reads until a masked compare matches or the poll budget runs out).
module hps_pio_master
    import hps_pio_pkg::*;
#(
    parameter int ADDR_W       = 2,
    parameter int DATA_W       = 32,
    parameter int READ_LATENCY = 1,
    parameter int WAIT_TIMEOUT = 255,
    parameter int MAX_POLLS    = 1023
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [ADDR_W-1:0] cmd_address,
    input  logic [DATA_W-1:0] cmd_data,
    input  logic [DATA_W-1:0] cmd_mask,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic [1:0]        rsp_status,
    output logic [ADDR_W-1:0] avm_address,
    output logic              avm_chipselect,
    output logic              avm_write_n,
    output logic [DATA_W-1:0] avm_writedata,
    input  logic [DATA_W-1:0] avm_readdata,
    input  logic              avm_waitrequest
);

    localparam int POLL_W = $clog2(MAX_POLLS + 1);
    localparam int WAIT_W = $clog2(WAIT_TIMEOUT + 1);

    state_e            state;
    state_e            state_nx;
    op_e               op_q;
    logic [DATA_W-1:0] mask_q;
    logic [POLL_W-1:0] poll_cnt;
    logic [WAIT_W-1:0] wait_cnt;
    logic              accept;
    logic              issue_done;
    logic              wait_hit;
    logic              lat_start;
    logic              capture;
    logic              poll_match;
    logic              poll_last;

    assign accept     = cmd_valid && (state == S_IDLE);
    assign issue_done = (state == S_ISSUE) && !avm_waitrequest;
    // The stalled cycle that brings the wait count up to WAIT_TIMEOUT is the last ISSUE cycle.
    assign wait_hit   = (state == S_ISSUE) && avm_waitrequest &&
                        (wait_cnt == WAIT_W'(WAIT_TIMEOUT - 1));
    assign lat_start  = issue_done && (op_q != OP_WRITE);
    // rsp_data holds the captured read word; avm_writedata holds the POLL compare value.
    assign poll_match = ((rsp_data & mask_q) == (avm_writedata & mask_q));
    assign poll_last  = (poll_cnt == POLL_W'(MAX_POLLS - 1));

    hps_pio_lat_pipe #(
        .READ_LATENCY(READ_LATENCY)
    ) u_lat_pipe (
        .clk    (clk),
        .reset  (reset),
        .start  (lat_start),
        .capture(capture)
    );

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= S_IDLE;
        else
            state <= state_nx;
    end

    // Next-state decode and state-derived handshake/bus strobes.
    always_comb begin
        state_nx       = state;
        cmd_ready      = 1'b0;
        avm_chipselect = 1'b0;
        avm_write_n    = 1'b1;
        rsp_valid      = 1'b0;
        case (state)
            S_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid)
                    state_nx = (cmd_op == OP_RSVD) ? S_RESP : S_ISSUE;
            end
            S_ISSUE: begin
                avm_chipselect = 1'b1;
                avm_write_n    = (op_q != OP_WRITE);
                if (!avm_waitrequest)
                    state_nx = (op_q == OP_WRITE) ? S_RESP : S_LAT;
                else if (wait_hit)
                    state_nx = S_RESP;
            end
            S_LAT: begin
                if (capture)
                    state_nx = S_EVAL;
            end
            S_EVAL: begin
                if ((op_q == OP_READ) || poll_match || poll_last)
                    state_nx = S_RESP;
                else
                    state_nx = S_ISSUE;
            end
            S_RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready)
                    state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // Command capture; bus address/data only change for ops that actually use the bus.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_q          <= OP_WRITE;
            mask_q        <= '0;
            avm_address   <= '0;
            avm_writedata <= '0;
        end else if (accept) begin
            op_q <= op_e'(cmd_op);
            if (cmd_op != OP_RSVD) begin
                mask_q        <= cmd_mask;
                avm_address   <= cmd_address;
                avm_writedata <= cmd_data;
            end
        end
    end

    // Stall counter: zero outside ISSUE so every ISSUE entry starts from zero; saturates.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            wait_cnt <= '0;
        else if (state != S_ISSUE)
            wait_cnt <= '0;
        else if (avm_waitrequest && (wait_cnt != WAIT_W'(WAIT_TIMEOUT)))
            wait_cnt <= wait_cnt + 1'b1;
    end

    // Poll counter: one count per non-matching POLL read, cleared per command.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            poll_cnt <= '0;
        else if (accept)
            poll_cnt <= '0;
        else if ((state == S_EVAL) && (op_q == OP_POLL) && !poll_match)
            poll_cnt <= poll_cnt + 1'b1;
    end

    // Response data/status, written only on the transitions that lead into RESP or capture.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rsp_data   <= '0;
            rsp_status <= ST_OK;
        end else if (accept && (cmd_op == OP_RSVD)) begin
            rsp_data   <= '0;
            rsp_status <= ST_BAD_OP;
        end else if (issue_done && (op_q == OP_WRITE)) begin
            rsp_data   <= '0;
            rsp_status <= ST_OK;
        end else if (wait_hit) begin
            rsp_data   <= '0;
            rsp_status <= ST_WAIT_TIMEOUT;
        end else if ((state == S_LAT) && capture) begin
            rsp_data <= avm_readdata;
        end else if (state == S_EVAL) begin
            if ((op_q == OP_POLL) && !poll_match && poll_last)
                rsp_status <= ST_POLL_EXHAUSTED;
            else
                rsp_status <= ST_OK;
        end
    end

endmodule

// File: tb/tb_hps_pio_master.sv
// Directed bench for hps_pio_master: a PIO-style slave model on the main instance and a
// second instance with a small poll budget and two-cycle read latency.
module tb_hps_pio_master;

    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_valid_p;
    logic [1:0]  cmd_op;
    logic [1:0]  cmd_address;
    logic [31:0] cmd_data;
    logic [31:0] cmd_mask;
    logic        rsp_ready;

    logic        a_cmd_ready, a_rsp_valid, a_cs, a_write_n, a_waitreq;
    logic [31:0] a_rsp_data, a_writedata, a_readdata;
    logic [1:0]  a_rsp_status, a_address;

    logic        p_cmd_ready, p_rsp_valid, p_cs, p_write_n;
    logic [31:0] p_rsp_data, p_writedata;
    logic [1:0]  p_rsp_status, p_address;
    wire  [31:0] p_readdata = 32'h0;

    logic [31:0] in_port;
    logic        poll_mode;
    int          poll_base;
    int          cs_cycles = 0, wr_cycles = 0, rd_count = 0, p_cs_cycles = 0;
    logic [31:0] last_wdata = '0;
    logic [1:0]  last_waddr = '0;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    hps_pio_master #(
        .ADDR_W(2), .DATA_W(32), .READ_LATENCY(1), .WAIT_TIMEOUT(4), .MAX_POLLS(1023)
    ) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(a_cmd_ready), .cmd_op(cmd_op),
        .cmd_address(cmd_address), .cmd_data(cmd_data), .cmd_mask(cmd_mask),
        .rsp_valid(a_rsp_valid), .rsp_ready(rsp_ready), .rsp_data(a_rsp_data),
        .rsp_status(a_rsp_status), .avm_address(a_address), .avm_chipselect(a_cs),
        .avm_write_n(a_write_n), .avm_writedata(a_writedata),
        .avm_readdata(a_readdata), .avm_waitrequest(a_waitreq)
    );

    hps_pio_master #(
        .ADDR_W(2), .DATA_W(32), .READ_LATENCY(2), .WAIT_TIMEOUT(255), .MAX_POLLS(3)
    ) dut_p (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid_p), .cmd_ready(p_cmd_ready), .cmd_op(cmd_op),
        .cmd_address(cmd_address), .cmd_data(cmd_data), .cmd_mask(cmd_mask),
        .rsp_valid(p_rsp_valid), .rsp_ready(rsp_ready), .rsp_data(p_rsp_data),
        .rsp_status(p_rsp_status), .avm_address(p_address), .avm_chipselect(p_cs),
        .avm_write_n(p_write_n), .avm_writedata(p_writedata),
        .avm_readdata(p_readdata), .avm_waitrequest(1'b0)
    );

    // PIO-style slave (latency 1) plus bus activity counters for both instances.
    always @(posedge clk) begin
        if (a_cs) cs_cycles <= cs_cycles + 1;
        if (a_cs && !a_write_n) begin
            wr_cycles  <= wr_cycles + 1;
            last_wdata <= a_writedata;
            last_waddr <= a_address;
        end
        if (a_cs && a_write_n && !a_waitreq) begin
            a_readdata <= poll_mode ? (((rd_count - poll_base) >= 5) ? 32'h1 : 32'h0) : in_port;
            rd_count   <= rd_count + 1;
        end
        if (p_cs) p_cs_cycles <= p_cs_cycles + 1;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Issues one command from a negedge with the target idle; returns the number of
    // negedges until rsp_valid is seen (accept happens on the first posedge).
    task automatic do_cmd(input bit to_p, input logic [1:0] op, input logic [1:0] addr,
                          input logic [31:0] data, input logic [31:0] mask, output int n);
        cmd_op = op; cmd_address = addr; cmd_data = data; cmd_mask = mask;
        if (to_p) cmd_valid_p = 1'b1; else cmd_valid = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
            cmd_valid = 1'b0;
            cmd_valid_p = 1'b0;
        end while (!(to_p ? p_rsp_valid : a_rsp_valid) && n < 5000);
        check("rsp_arrived", (n < 5000), 1);
    endtask

    initial begin
        int n;
        int cs0, wr0;
        reset = 1'b1; cmd_valid = 1'b0; cmd_valid_p = 1'b0; cmd_op = 2'd0;
        cmd_address = '0; cmd_data = '0; cmd_mask = '0; rsp_ready = 1'b1;
        a_waitreq = 1'b0; in_port = '0; poll_mode = 1'b0; poll_base = 0;

        // Reset values
        repeat (2) @(negedge clk);
        check("rst_cs", a_cs, 0);
        check("rst_write_n", a_write_n, 1);
        check("rst_rsp_valid", a_rsp_valid, 0);
        check("rst_bus", {a_address, a_writedata}, 0);
        check("rst_rsp", {a_rsp_status, a_rsp_data}, 0);
        reset = 1'b0;
        @(negedge clk);
        check("rst_cmd_ready", a_cmd_ready, 1);

        // READ addr 0 from in_port 0x12345678: response 3+RL cycles after accept
        in_port = 32'h12345678;
        do_cmd(0, 2'd1, 2'd0, 32'h0, 32'h0, n);
        check("rd_latency", n, 4);
        check("rd_data", a_rsp_data, 32'h12345678);
        check("rd_status", a_rsp_status, 0);
        @(negedge clk);
        check("rd_back_idle", a_cmd_ready, 1);

        // WRITE addr 0 0xDEADBEEF: one write strobe, response after 2, idle at 3
        cs0 = cs_cycles; wr0 = wr_cycles;
        do_cmd(0, 2'd0, 2'd0, 32'hDEADBEEF, 32'h0, n);
        check("wr_latency", n, 2);
        check("wr_rsp", {a_rsp_status, a_rsp_data}, 0);
        check("wr_cs_cycles", cs_cycles - cs0, 1);
        check("wr_strobes", wr_cycles - wr0, 1);
        check("wr_wdata", last_wdata, 32'hDEADBEEF);
        check("wr_no_same_cycle_accept", a_cmd_ready, 0);
        @(negedge clk);
        check("wr_back_idle", {a_cmd_ready, a_rsp_valid}, 2'b10);

        // WRITE to the top address
        do_cmd(0, 2'd0, 2'd3, 32'hA5A50F0F, 32'h0, n);
        check("wr3_addr", last_waddr, 2'd3);
        check("wr3_wdata", last_wdata, 32'hA5A50F0F);
        @(negedge clk);

        // POLL bit0 == 1; slave sets bit0 from the 6th read on
        poll_mode = 1'b1; poll_base = rd_count; cs0 = cs_cycles;
        do_cmd(0, 2'd2, 2'd1, 32'h1, 32'h1, n);
        check("poll_cs_pulses", cs_cycles - cs0, 6);
        check("poll_latency", n, 19);
        check("poll_status", a_rsp_status, 0);
        check("poll_data", a_rsp_data, 32'h1);
        poll_mode = 1'b0;
        @(negedge clk);

        // Reserved op: no bus activity, BAD_OP with zero data
        cs0 = cs_cycles;
        do_cmd(0, 2'd3, 2'd2, 32'hFFFFFFFF, 32'h0, n);
        check("badop_latency", n, 1);
        check("badop_rsp", {a_rsp_status, a_rsp_data}, {2'd3, 32'h0});
        check("badop_no_bus", cs_cycles - cs0, 0);
        @(negedge clk);

        // POLL matching on the first read only through the mask
        in_port = 32'hABCD00F0; cs0 = cs_cycles;
        do_cmd(0, 2'd2, 2'd2, 32'h000000F0, 32'h0000F0F0, n);
        check("pollm_cs_pulses", cs_cycles - cs0, 1);
        check("pollm_rsp", {a_rsp_status, a_rsp_data}, {2'd0, 32'hABCD00F0});
        @(negedge clk);

        // waitrequest stuck high: 4 chipselect cycles then WAIT_TIMEOUT; response held
        a_waitreq = 1'b1; cs0 = cs_cycles;
        do_cmd(0, 2'd1, 2'd1, 32'h0, 32'h0, n);
        rsp_ready = 1'b0;
        check("to_latency", n, 5);
        check("to_cs_cycles", cs_cycles - cs0, 4);
        check("to_rsp", {a_rsp_status, a_rsp_data}, {2'd1, 32'h0});
        repeat (10) begin
            @(negedge clk);
            check("to_hold", {a_rsp_valid, a_cs, a_rsp_status, a_rsp_data}, {1'b1, 1'b0, 2'd1, 32'h0});
        end
        check("to_no_reissue", cs_cycles - cs0, 4);
        rsp_ready = 1'b1;
        @(negedge clk);
        check("to_back_idle", {a_cmd_ready, a_rsp_valid}, 2'b10);
        a_waitreq = 1'b0;

        // Reset while in LAT aborts the read with no response
        in_port = 32'h55AA55AA;
        cmd_op = 2'd1; cmd_address = 2'd2; cmd_data = 32'h13579BDF; cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        check("abort_in_issue", a_cs, 1);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("abort_bus", {a_cs, a_write_n, a_address, a_writedata}, {1'b0, 1'b1, 2'd0, 32'h0});
        check("abort_rsp", {a_rsp_valid, a_rsp_status, a_rsp_data}, 0);
        @(negedge clk);
        reset = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("abort_no_rsp", {a_rsp_valid, a_cmd_ready}, 2'b01);
        end
        in_port = 32'h0F1E2D3C;
        do_cmd(0, 2'd1, 2'd1, 32'h0, 32'h0, n);
        check("post_abort_latency", n, 4);
        check("post_abort_rsp", {a_rsp_status, a_rsp_data}, {2'd0, 32'h0F1E2D3C});
        @(negedge clk);

        // Second instance: MAX_POLLS=3, never matches, READ_LATENCY=2
        cs0 = p_cs_cycles;
        do_cmd(1, 2'd2, 2'd0, 32'h1, 32'h1, n);
        check("exh_reads", p_cs_cycles - cs0, 3);
        check("exh_latency", n, 13);
        check("exh_rsp", {p_rsp_status, p_rsp_data}, {2'd2, 32'h0});
        @(negedge clk);
        check("exh_back_idle", p_cmd_ready, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/hps_pio_master.md
HPS_PIO_MASTER -- requirements
Module: hps_pio_master

Interface
REQ-001 Parameter ADDR_W, default 2: width of the Avalon-MM word address.
REQ-002 Parameter DATA_W, default 32: data width.
REQ-003 Parameter READ_LATENCY, default 1: cycles from accepted read to valid avm_readdata; legal range 1..4.
REQ-004 Parameter WAIT_TIMEOUT, default 255: maximum waitrequest cycles per access before abort.
REQ-005 Parameter MAX_POLLS, default 1023: maximum reads per POLL command.
REQ-006 clk  in  1  single clock for all logic.
REQ-007 reset  in  1  asynchronous, active-high reset.
REQ-008 cmd_valid  in  1  command present.
REQ-009 cmd_ready  out  1  block accepts command this cycle.
REQ-010 cmd_op  in  2  0=WRITE, 1=READ, 2=POLL, 3=reserved.
REQ-011 cmd_address  in  ADDR_W  target word address.
REQ-012 cmd_data  in  DATA_W  write data (WRITE) or compare value (POLL).
REQ-013 cmd_mask  in  DATA_W  POLL compare mask.
REQ-014 rsp_valid  out  1  response present.
REQ-015 rsp_ready  in  1  response consumed.
REQ-016 rsp_data  out  DATA_W  last read data; 0 for WRITE.
REQ-017 rsp_status  out  2  0=OK, 1=WAIT_TIMEOUT, 2=POLL_EXHAUSTED, 3=BAD_OP.
REQ-018 avm_address  out  ADDR_W  Avalon-MM address.
REQ-019 avm_chipselect  out  1  access strobe.
REQ-020 avm_write_n  out  1  active-low write qualifier.
REQ-021 avm_writedata  out  DATA_W  write data.
REQ-022 avm_readdata  in  DATA_W  read data, fixed latency.
REQ-023 avm_waitrequest  in  1  slave stall; tie 0 for slaves without it.

Function
REQ-024 FSM states SHALL be IDLE, ISSUE, LAT, EVAL, RESP.
REQ-025 cmd_ready SHALL be 1 only in IDLE; command fields are registered on cmd_valid&&cmd_ready, and the FSM enters ISSUE next cycle.
REQ-026 cmd_op=3 SHALL skip the bus, go IDLE->RESP with rsp_status=3 and rsp_data=0.
REQ-027 In ISSUE: avm_chipselect=1, avm_address=registered address, avm_write_n=0 only for WRITE, avm_writedata=cmd_data; all held stable while avm_waitrequest=1.
REQ-028 ISSUE exit on avm_waitrequest=0: WRITE->RESP with status 0; READ/POLL->LAT.
REQ-029 Outside ISSUE: avm_chipselect=0, avm_write_n=1; address/writedata hold their last value.
REQ-030 LAT SHALL count so that avm_readdata is captured exactly READ_LATENCY cycles after the non-stalled ISSUE cycle; the FSM then enters EVAL.
REQ-031 EVAL: READ->RESP with status 0; POLL->RESP with status 0 if ((rd & cmd_mask) == (cmd_data & cmd_mask)).
REQ-032 EVAL, POLL no match: increment poll count; if count == MAX_POLLS ->RESP with status 2, else ->ISSUE.
REQ-033 Wait counter SHALL clear on ISSUE entry and increment per stalled cycle; on reaching WAIT_TIMEOUT, chipselect drops the following cycle and the FSM goes to RESP with status 1 and rsp_data=0.
REQ-034 RESP: rsp_valid=1, rsp_data/rsp_status stable until rsp_ready; rsp_valid&&rsp_ready ->IDLE. No new command is accepted in the same cycle.
REQ-035 Minimum WRITE round trip with no stall and rsp_ready=1 SHALL be 3 cycles from accept to IDLE. Minimum READ round trip SHALL be 4+READ_LATENCY cycles.
REQ-036 Poll count width SHALL be clog2(MAX_POLLS+1). Wait count width SHALL be clog2(WAIT_TIMEOUT+1). Neither counter SHALL wrap.

Reset
REQ-037 On reset: state IDLE, cmd_ready=1 after release, rsp_valid=0, rsp_data=0, rsp_status=0, avm_chipselect=0, avm_write_n=1, avm_address=0, avm_writedata=0, counters 0.
REQ-038 Reset asserted mid-access SHALL abort it immediately; no response is produced for the aborted command.

Structure
REQ-039 Shared package hps_pio_pkg SHALL hold the op encodings, status encodings and FSM state enum.
REQ-040 One sub-module, hps_pio_lat_pipe, SHALL implement the READ_LATENCY countdown and capture strobe.

Verification
REQ-041 WRITE addr 0, data 0xDEADBEEF, no stall -> one chipselect cycle with write_n=0 and writedata 0xDEADBEEF; rsp status 0 and data 0 on cycle 3.
REQ-042 READ addr 0 with a PIO-style slave whose in_port=0x12345678, READ_LATENCY=1 -> rsp_data 0x12345678, status 0.
REQ-043 POLL mask 0x1, value 0x1; in_port bit0 set after 5 reads -> exactly 6 chipselect pulses, status 0.
REQ-044 POLL with MAX_POLLS=3 and no match -> 3 reads, status 2.
REQ-045 waitrequest held high with WAIT_TIMEOUT=4 -> chipselect stays high 4 cycles then drops; status 1. rsp_ready held low 10 cycles -> rsp_valid and data remain stable.
REQ-046 Reset asserted during LAT -> outputs return to reset values, no rsp_valid; the next READ completes normally.
